// File: rtl/product_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : product_accumulator_pkg
// Brief   : Shared state encoding and default widths for the MAC datapath.
// Revision: 1.0
// ============================================================================
package product_accumulator_pkg;

  localparam int DEF_PRODUCT_WIDTH = 16;
  localparam int DEF_ACC_WIDTH     = 24;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

endpackage : product_accumulator_pkg
`default_nettype wire

// File: rtl/product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module  : product_accumulator_if
// Brief   : Product input and result output handshakes of the accumulator.
// Revision: 1.0
// ============================================================================
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH
);

  logic                     clear;
  logic                     in_valid;
  logic                     in_ready;
  logic [PRODUCT_WIDTH-1:0] in_product;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_WIDTH-1:0]     out_sum;
  logic                     out_overflow;

  modport master (
    output clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

  modport slave (
    input  clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );

endinterface : product_accumulator_if
`default_nettype wire

// File: rtl/sat_detect_add.sv
`default_nettype none
// ============================================================================
// Module  : sat_detect_add
// Brief   : Wrapping signed adder that also reports two's-complement overflow.
// Revision: 1.0
// ============================================================================
module sat_detect_add
  import product_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_ACC_WIDTH
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic      [WIDTH-1:0] o_sum,
  output logic                  o_overflow
);

  always_comb begin
    o_sum      = i_a + i_b;
    // Overflow only when both operands share a sign that the result lost.
    o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
  end

endmodule : sat_detect_add
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : product_accumulator
// Brief   : Sums COUNT signed products and presents the result on valid/ready.
// Revision: 1.0
// ============================================================================
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PRODUCT_WIDTH = DEF_PRODUCT_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int COUNT         = 4,
  parameter int CNT_WIDTH     = 3
) (
  input wire logic             clk,
  input wire logic             rst,
  product_accumulator_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] c_count_last = CNT_WIDTH'(COUNT - 1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_add_ovf;

  assign w_ext = ACC_WIDTH'($signed(bus.in_product));

  sat_detect_add #(
    .WIDTH (ACC_WIDTH)
  ) u_add (
    .i_a        (acc_q),
    .i_b        (w_ext),
    .o_sum      (w_sum),
    .o_overflow (w_add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    // clear overrides both an accept and an output handshake in the same cycle.
    if (bus.clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            acc_d   = w_sum;
            ovf_d   = ovf_q | w_add_ovf;
            count_d = count_q + CNT_WIDTH'(1);
            if (count_q == c_count_last) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // The accumulator itself is the result register; it is frozen while in DONE.
  assign bus.in_ready     = (state_q == ST_ACCUM);
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.out_sum      = acc_q;
  assign bus.out_overflow = ovf_q;

endmodule : product_accumulator
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_product_accumulator
// Brief   : Directed and randomized checks of product_accumulator.
// Revision: 1.0
// ============================================================================
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24)) d_if ();
  product_accumulator_if #(.PRODUCT_WIDTH(16), .ACC_WIDTH(16)) o_if ();
  product_accumulator_if #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24)) c_if ();

  product_accumulator #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24), .COUNT(4), .CNT_WIDTH(3))
    u_def (.clk(clk), .rst(rst), .bus(d_if));
  product_accumulator #(.PRODUCT_WIDTH(16), .ACC_WIDTH(16), .COUNT(4), .CNT_WIDTH(3))
    u_ovf (.clk(clk), .rst(rst), .bus(o_if));
  product_accumulator #(.PRODUCT_WIDTH(16), .ACC_WIDTH(24), .COUNT(1), .CNT_WIDTH(1))
    u_one (.clk(clk), .rst(rst), .bus(c_if));

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer sum, wrapped into w bits, overflow when any step leaves range.
  function automatic void model_sum(input int prods[$], input int w,
                                    output longint s, output bit o);
    longint lo, hi, m;
    lo = -(64'sd1 <<< (w - 1));
    hi = -lo - 1;
    m  = 64'sd1 <<< w;
    s  = 0;
    o  = 1'b0;
    foreach (prods[i]) begin
      s = s + prods[i];
      if (s > hi) begin o = 1'b1; s = s - m; end
      else if (s < lo) begin o = 1'b1; s = s + m; end
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    n_cmp++; if (d_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", d_if.in_ready); end
    n_cmp++; if (d_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", d_if.out_valid); end
    n_cmp++; if (d_if.out_sum !== 24'd0) begin n_bad++; $display("FAIL reset_out_sum: got %h want 0", d_if.out_sum); end
    n_cmp++; if (d_if.out_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", d_if.out_overflow); end
  endtask

  task automatic test_basic_sum();
    int prods[4] = '{3, -5, 100, 2};
    d_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_if.in_valid   = 1'b1;
      d_if.in_product = 16'(prods[i]);
      cycle();
      if (i < 3) begin
        n_cmp++; if (d_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, d_if.out_valid); end
      end
    end
    d_if.in_valid = 1'b0;
    n_cmp++; if (d_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", d_if.out_valid); end
    n_cmp++; if (d_if.out_sum !== 24'd100) begin n_bad++; $display("FAIL basic_sum: got %0d want 100", $signed(d_if.out_sum)); end
    n_cmp++; if (d_if.out_overflow !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", d_if.out_overflow); end
    n_cmp++; if (d_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_done: got %b want 0", d_if.in_ready); end
    cycle();
    n_cmp++; if (d_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_single_pulse: got %b want 0", d_if.out_valid); end
    n_cmp++; if (d_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready_after: got %b want 1", d_if.in_ready); end
  endtask

  task automatic test_backpressure();
    d_if.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      d_if.in_valid = 1'b1; d_if.in_product = 16'(i * 10); cycle();
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (d_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", k, d_if.out_valid); end
      n_cmp++; if (d_if.out_sum !== 24'd100) begin n_bad++; $display("FAIL bp_sum[%0d]: got %0d want 100", k, $signed(d_if.out_sum)); end
      n_cmp++; if (d_if.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, d_if.in_ready); end
      d_if.in_valid   = (k % 2 == 0);
      d_if.in_product = 16'($urandom);
      cycle();
    end
    d_if.in_valid  = 1'b0;
    d_if.out_ready = 1'b1;
    cycle();
    n_cmp++; if (d_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_handshake: got %b want 0", d_if.out_valid); end
    for (int i = 1; i <= 4; i++) begin
      d_if.in_valid = 1'b1; d_if.in_product = 16'(i); cycle();
    end
    d_if.in_valid = 1'b0;
    n_cmp++; if (d_if.out_sum !== 24'd10) begin n_bad++; $display("FAIL bp_next_sum: got %0d want 10", $signed(d_if.out_sum)); end
    cycle();
  endtask

  task automatic test_clear();
    d_if.out_ready = 1'b1;
    d_if.in_valid = 1'b1; d_if.in_product = 16'd7; cycle();
    d_if.in_product = 16'd9; cycle();
    d_if.clear = 1'b1; d_if.in_product = 16'd50; cycle();
    d_if.clear = 1'b0; d_if.in_valid = 1'b0;
    n_cmp++; if (d_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL clear_in_ready: got %b want 1", d_if.in_ready); end
    n_cmp++; if (d_if.out_sum !== 24'd0) begin n_bad++; $display("FAIL clear_acc: got %0d want 0", $signed(d_if.out_sum)); end
    for (int i = 0; i < 4; i++) begin
      d_if.in_valid = 1'b1; d_if.in_product = 16'd1; cycle();
      if (i < 3) begin
        n_cmp++; if (d_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL clear_count[%0d]: got %b want 0", i, d_if.out_valid); end
      end
    end
    d_if.in_valid = 1'b0;
    n_cmp++; if (d_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL clear_valid: got %b want 1", d_if.out_valid); end
    n_cmp++; if (d_if.out_sum !== 24'd4) begin n_bad++; $display("FAIL clear_sum: got %0d want 4", $signed(d_if.out_sum)); end
    cycle();
  endtask

  task automatic test_reset_mid_output();
    int prods[4] = '{3, -5, 100, 2};
    d_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_if.in_valid = 1'b1; d_if.in_product = 16'(prods[i]); cycle();
    end
    d_if.in_valid = 1'b0;
    n_cmp++; if (d_if.out_sum !== 24'd100) begin n_bad++; $display("FAIL rmo_pre_sum: got %0d want 100", $signed(d_if.out_sum)); end
    rst = 1'b1; cycle(); rst = 1'b0;
    n_cmp++; if (d_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmo_valid: got %b want 0", d_if.out_valid); end
    n_cmp++; if (d_if.out_sum !== 24'd0) begin n_bad++; $display("FAIL rmo_sum: got %h want 0", d_if.out_sum); end
    n_cmp++; if (d_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmo_in_ready: got %b want 1", d_if.in_ready); end
    for (int i = 0; i < 4; i++) begin
      d_if.in_valid = 1'b1; d_if.in_product = 16'hFFFF; cycle();
    end
    d_if.in_valid = 1'b0;
    n_cmp++; if (d_if.out_sum !== 24'hFFFFFC) begin n_bad++; $display("FAIL rmo_neg_sum: got %h want fffffc", d_if.out_sum); end
    d_if.out_ready = 1'b1; cycle();
  endtask

  task automatic test_overflow();
    int prods[4] = '{32767, 1, 0, 0};
    o_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      o_if.in_valid = 1'b1; o_if.in_product = 16'(prods[i]); cycle();
    end
    o_if.in_valid = 1'b0;
    n_cmp++; if (o_if.out_sum !== 16'h8000) begin n_bad++; $display("FAIL ovf_sum: got %h want 8000", o_if.out_sum); end
    n_cmp++; if (o_if.out_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", o_if.out_overflow); end
    cycle();
    for (int i = 0; i < 4; i++) begin
      o_if.in_valid = 1'b1; o_if.in_product = 16'd1; cycle();
    end
    o_if.in_valid = 1'b0;
    n_cmp++; if (o_if.out_sum !== 16'd4) begin n_bad++; $display("FAIL ovf_next_sum: got %h want 0004", o_if.out_sum); end
    n_cmp++; if (o_if.out_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_cleared: got %b want 0", o_if.out_overflow); end
    cycle();
  endtask

  task automatic test_count_one();
    c_if.out_ready = 1'b1;
    c_if.in_valid = 1'b1; c_if.in_product = 16'd5; cycle();
    n_cmp++; if (c_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL c1_valid_a: got %b want 1", c_if.out_valid); end
    n_cmp++; if (c_if.out_sum !== 24'd5) begin n_bad++; $display("FAIL c1_sum_a: got %0d want 5", $signed(c_if.out_sum)); end
    c_if.in_product = 16'd77; cycle();
    c_if.in_valid = 1'b0;
    n_cmp++; if (c_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL c1_no_accept_in_done: got %b want 0", c_if.out_valid); end
    repeat (2) cycle();
    n_cmp++; if (c_if.in_ready !== 1'b1) begin n_bad++; $display("FAIL c1_idle_ready: got %b want 1", c_if.in_ready); end
    c_if.in_valid = 1'b1; c_if.in_product = 16'hFFFD; cycle();
    c_if.in_valid = 1'b0;
    n_cmp++; if (c_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL c1_valid_b: got %b want 1", c_if.out_valid); end
    n_cmp++; if (c_if.out_sum !== 24'hFFFFFD) begin n_bad++; $display("FAIL c1_sum_b: got %h want fffffd", c_if.out_sum); end
    cycle();
    n_cmp++; if (c_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL c1_valid_end: got %b want 0", c_if.out_valid); end
  endtask

  task automatic test_random();
    int              q[$];
    bit              mdl_done = 1'b0;
    longint          es = 0;
    bit              eo = 1'b0;
    bit              cl, iv, orr;
    logic signed [15:0] rp;
    d_if.clear = 1'b1; d_if.in_valid = 1'b0; cycle();
    d_if.clear = 1'b0;
    for (int n = 0; n < 400; n++) begin
      n_cmp++; if (d_if.in_ready !== !mdl_done) begin n_bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, d_if.in_ready, !mdl_done); end
      n_cmp++; if (d_if.out_valid !== mdl_done) begin n_bad++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", n, d_if.out_valid, mdl_done); end
      if (mdl_done) begin
        n_cmp++; if (d_if.out_sum !== 24'(es)) begin n_bad++; $display("FAIL rnd_sum[%0d]: got %h want %h", n, d_if.out_sum, 24'(es)); end
        n_cmp++; if (d_if.out_overflow !== eo) begin n_bad++; $display("FAIL rnd_ovf[%0d]: got %b want %b", n, d_if.out_overflow, eo); end
      end
      cl  = ($urandom_range(0, 29) == 0);
      iv  = ($urandom_range(0, 9) < 7);
      orr = ($urandom_range(0, 9) < 6);
      rp  = 16'($urandom);
      d_if.clear = cl; d_if.in_valid = iv; d_if.out_ready = orr; d_if.in_product = rp;
      if (cl) begin
        q.delete(); mdl_done = 1'b0;
      end else if (!mdl_done) begin
        if (iv) begin
          q.push_back(int'(rp));
          if (q.size() == 4) begin
            model_sum(q, 24, es, eo);
            mdl_done = 1'b1;
          end
        end
      end else if (orr) begin
        q.delete(); mdl_done = 1'b0;
      end
      cycle();
    end
    d_if.clear = 1'b0; d_if.in_valid = 1'b0; d_if.out_ready = 1'b0;
  endtask

  initial begin
    d_if.clear = 1'b0; d_if.in_valid = 1'b0; d_if.in_product = '0; d_if.out_ready = 1'b0;
    o_if.clear = 1'b0; o_if.in_valid = 1'b0; o_if.in_product = '0; o_if.out_ready = 1'b0;
    c_if.clear = 1'b0; c_if.in_valid = 1'b0; c_if.in_product = '0; c_if.out_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_backpressure();
    test_clear();
    test_reset_mid_output();
    test_overflow();
    test_count_one();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_product_accumulator
`default_nettype wire
